set_assoc_cache: RTL and testbench

SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

---
 rtl/set_assoc_cache_pkg.sv | 39 +++
 rtl/cache_lru.sv | 61 ++++++
 rtl/set_assoc_cache.sv | 254 +++++++++++++++++++++++++
 tb/tb_set_assoc_cache.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_assoc_cache_pkg.sv
// rtl/set_assoc_cache_pkg.sv - FSM states, line metadata record and address-field width helpers
package set_assoc_cache_pkg;

  // Widest tag any configuration may need; narrower tags are zero-extended.
  localparam int TAG_MAX = 32;

  typedef enum logic [2:0] {
    IDLE,
    RESPOND,
    WRITEBACK,
    REFILL,
    FLUSH_SCAN,
    FLUSH_WB
  } state_t;

  // Per-line control record; the block words live in a parallel data array.
  typedef struct packed {
    logic               valid;
    logic               dirty;
    logic [TAG_MAX-1:0] tag;
  } line_meta_t;

  function automatic int off_w(input int words);
    return $clog2(words) + 2;
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int words, input int sets);
    return addr_w - off_w(words) - idx_w(sets);
  endfunction

  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - per-set age counters with invalid-first / least-recently-used victim selection
module cache_lru
  import set_assoc_cache_pkg::*;
#(
  parameter int SETS = 2,
  parameter int WAYS = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     init,
  input  logic                     touch,
  input  logic [idx_w(SETS)-1:0]   touch_set,
  input  logic [way_w(WAYS)-1:0]   touch_way,
  input  logic [idx_w(SETS)-1:0]   lookup_set,
  input  logic [WAYS-1:0]          valid_vec,
  output logic [way_w(WAYS)-1:0]   victim_way
);

  localparam int AGE_W = way_w(WAYS);
  localparam int WAY_W = way_w(WAYS);

  logic [AGE_W-1:0] age [SETS][WAYS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= AGE_W'(w);
    end else if (init) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          age[s][w] <= AGE_W'(w);
    end else if (touch) begin
      // Ages stay a permutation of 0..WAYS-1 within each set.
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == touch_way)
          age[touch_set][w] <= '0;
        else if (age[touch_set][w] < age[touch_set][touch_way])
          age[touch_set][w] <= age[touch_set][w] + 1'b1;
      end
    end
  end

  always_comb begin
    logic found;
    found      = 1'b0;
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_vec[w] && !found) begin
        victim_way = WAY_W'(w);
        found      = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++)
        if (age[lookup_set][w] == AGE_W'(WAYS - 1))
          victim_way = WAY_W'(w);
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - write-back, write-allocate set-associative cache with flush
module set_assoc_cache
  import set_assoc_cache_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  parameter int SETS   = 2,
  parameter int WAYS   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_we,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [WORD_W-1:0]         req_wdata,
  output logic                      resp_valid,
  output logic                      resp_hit,
  output logic [WORD_W-1:0]         resp_rdata,
  input  logic                      flush,
  output logic                      flush_done,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [WORDS*WORD_W-1:0]   mem_wdata,
  input  logic [WORDS*WORD_W-1:0]   mem_rdata,
  input  logic                      mem_ack
);

  localparam int OFF_W  = off_w(WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, WORDS, SETS);
  localparam int WSEL_W = $clog2(WORDS);
  localparam int WAY_W  = way_w(WAYS);
  localparam int BLK_W  = WORDS * WORD_W;

  state_t state, state_nx;

  line_meta_t       meta [SETS][WAYS];
  logic [BLK_W-1:0] data [SETS][WAYS];

  logic              r_we;
  logic [ADDR_W-1:2] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [WAY_W-1:0]  r_way;
  logic              hit_q;
  logic [WORD_W-1:0] rdata_q;
  logic [IDX_W-1:0]  fs_set;
  logic [WAY_W-1:0]  fs_way;

  logic [IDX_W-1:0]  req_idx, r_idx;
  logic [TAG_W-1:0]  req_tag, r_tag;
  logic [WSEL_W-1:0] req_wsel, r_wsel;
  logic              unused_addr_lsb;

  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_wsel = req_addr[2 +: WSEL_W];
  assign r_idx    = r_addr[OFF_W +: IDX_W];
  assign r_tag    = r_addr[ADDR_W-1 -: TAG_W];
  assign r_wsel   = r_addr[2 +: WSEL_W];
  assign unused_addr_lsb = ^req_addr[1:0];

  logic              hit;
  logic [WAY_W-1:0]  hit_way, victim;
  logic [WAYS-1:0]   valid_vec;
  logic              victim_dirty, fs_dirty, fs_last;
  logic [WORD_W-1:0] hit_word, refill_word;
  logic [BLK_W-1:0]  hit_blk, refill_blk;
  logic              accept, lru_touch, lru_init;
  logic [IDX_W-1:0]  lru_set;
  logic [WAY_W-1:0]  lru_way;

  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    valid_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      valid_vec[w] = meta[req_idx][w].valid;
      if (!hit && meta[req_idx][w].valid && meta[req_idx][w].tag == TAG_MAX'(req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    hit_word = data[req_idx][hit_way][req_wsel*WORD_W +: WORD_W];
    hit_blk  = data[req_idx][hit_way];
    hit_blk[req_wsel*WORD_W +: WORD_W] = req_wdata;
    refill_blk = mem_rdata;
    if (r_we)
      refill_blk[r_wsel*WORD_W +: WORD_W] = r_wdata;
    refill_word = refill_blk[r_wsel*WORD_W +: WORD_W];
  end

  assign victim_dirty = meta[req_idx][victim].valid && meta[req_idx][victim].dirty;
  assign fs_dirty     = meta[fs_set][fs_way].valid && meta[fs_set][fs_way].dirty;
  assign fs_last      = (fs_set == IDX_W'(SETS - 1)) && (fs_way == WAY_W'(WAYS - 1));

  cache_lru #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_lru (
    .clk        (clk),
    .reset      (reset),
    .init       (lru_init),
    .touch      (lru_touch),
    .touch_set  (lru_set),
    .touch_way  (lru_way),
    .lookup_set (req_idx),
    .valid_vec  (valid_vec),
    .victim_way (victim)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_rdata = '0;
    flush_done = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    accept     = 1'b0;
    lru_touch  = 1'b0;
    lru_init   = 1'b0;
    lru_set    = req_idx;
    lru_way    = hit_way;
    case (state)
      IDLE: begin
        req_ready = !flush;
        if (flush) begin
          state_nx = FLUSH_SCAN;
        end else if (req_valid) begin
          accept = 1'b1;
          if (hit) begin
            lru_touch = 1'b1;
            state_nx  = RESPOND;
          end else begin
            state_nx = victim_dirty ? WRITEBACK : REFILL;
          end
        end
      end
      RESPOND: begin
        resp_valid = 1'b1;
        resp_hit   = hit_q;
        resp_rdata = rdata_q;
        state_nx   = IDLE;
      end
      WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {meta[r_idx][r_way].tag[TAG_W-1:0], r_idx, {OFF_W{1'b0}}};
        mem_wdata = data[r_idx][r_way];
        if (mem_ack) state_nx = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        if (mem_ack) begin
          lru_touch = 1'b1;
          lru_set   = r_idx;
          lru_way   = r_way;
          state_nx  = RESPOND;
        end
      end
      FLUSH_SCAN: begin
        if (fs_dirty) begin
          state_nx = FLUSH_WB;
        end else if (fs_last) begin
          flush_done = 1'b1;
          lru_init   = 1'b1;
          state_nx   = IDLE;
        end
      end
      FLUSH_WB: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {meta[fs_set][fs_way].tag[TAG_W-1:0], fs_set, {OFF_W{1'b0}}};
        mem_wdata = data[fs_set][fs_way];
        if (mem_ack) state_nx = FLUSH_SCAN;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_way   <= '0;
      hit_q   <= 1'b0;
      rdata_q <= '0;
      fs_set  <= '0;
      fs_way  <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          meta[s][w] <= '0;
    end else begin
      if (accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr[ADDR_W-1:2];
        r_wdata <= req_wdata;
        hit_q   <= hit;
        r_way   <= hit ? hit_way : victim;
        if (hit) begin
          rdata_q <= req_we ? req_wdata : hit_word;
          if (req_we) meta[req_idx][hit_way].dirty <= 1'b1;
        end
      end
      if (state == REFILL && mem_ack) begin
        meta[r_idx][r_way] <= '{valid: 1'b1, dirty: r_we, tag: TAG_MAX'(r_tag)};
        rdata_q            <= refill_word;
      end
      if (state == IDLE && flush) begin
        fs_set <= '0;
        fs_way <= '0;
      end
      // Clearing dirty sends the scan back over the same line, which now advances.
      if (state == FLUSH_WB && mem_ack)
        meta[fs_set][fs_way].dirty <= 1'b0;
      if (state == FLUSH_SCAN && !fs_dirty) begin
        if (fs_last) begin
          for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
              meta[s][w] <= '0;
        end else if (fs_way == WAY_W'(WAYS - 1)) begin
          fs_way <= '0;
          fs_set <= fs_set + 1'b1;
        end else begin
          fs_way <= fs_way + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept && hit && req_we)
      data[req_idx][hit_way] <= hit_blk;
    if (state == REFILL && mem_ack)
      data[r_idx][r_way] <= refill_blk;
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - directed self-checking bench for set_assoc_cache
module tb_set_assoc_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_we, flush, mem_ack;
  logic         req_ready, resp_valid, resp_hit, flush_done, mem_req, mem_we;
  logic [9:0]   req_addr, mem_addr;
  logic [31:0]  req_wdata, resp_rdata;
  logic [127:0] mem_wdata, mem_rdata;

  set_assoc_cache #(
    .ADDR_W (10), .WORD_W (32), .WORDS (4), .SETS (2), .WAYS (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_rdata (resp_rdata),
    .flush      (flush),
    .flush_done (flush_done),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  int           n_checks = 0;
  int           n_errors = 0;
  logic [127:0] mem [64];
  logic [9:0]   wb_addr_q[$];
  logic [127:0] wb_blk_q[$];
  logic [9:0]   rf_addr_q[$];
  logic         last_hit;
  logic [31:0]  last_rdata;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wb_addr_q.delete();
    wb_blk_q.delete();
    rf_addr_q.delete();
  endtask

  // Memory responder: holds one wait cycle, checks the request is stable, then acks.
  task automatic wait_evt(input bit for_flush);
    int         n;
    bit         done;
    logic [9:0] a0;
    logic       we0;
    n    = 0;
    done = 0;
    while (!done && n < 400) begin
      if (for_flush ? flush_done : resp_valid) begin
        done = 1;
      end else if (mem_req) begin
        a0  = mem_addr;
        we0 = mem_we;
        if (mem_we) begin
          wb_addr_q.push_back(mem_addr);
          wb_blk_q.push_back(mem_wdata);
          mem[mem_addr[9:4]] = mem_wdata;
        end else begin
          rf_addr_q.push_back(mem_addr);
          mem_rdata = mem[mem_addr[9:4]];
        end
        step();
        check("mem_hold", {mem_req, mem_we, mem_addr}, {1'b1, we0, a0});
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        n += 2;
      end else begin
        step();
        n++;
      end
    end
    if (!done) begin
      if (for_flush) check("tmo_flush", flush_done, 1'b1);
      else           check("tmo_resp", resp_valid, 1'b1);
    end
  endtask

  task automatic do_req(input logic we, input logic [9:0] addr, input logic [31:0] wdata);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 400) begin
      step();
      n++;
    end
    if (n >= 400) check("tmo_ready", req_ready, 1'b1);
    step();
    // Scramble request inputs while busy; the registered copy must be used.
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 10'h3FC;
    req_wdata = 32'hDEAD_BEEF;
    wait_evt(1'b0);
    last_hit   = resp_hit;
    last_rdata = resp_rdata;
    step();
    req_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    for (int b = 0; b < 64; b++)
      for (int i = 0; i < 4; i++)
        mem[b][i*32 +: 32] = 32'hA000_0000 | 32'(b << 8) | 32'(i);

    step();
    check("rst_ready", req_ready, 1'b1);
    check("rst_outs", {resp_valid, resp_hit, flush_done, mem_req, mem_we}, 5'b0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_maddr", mem_addr, 10'h0);
    check("rst_mwdata", mem_wdata, 128'h0);
    step();
    reset = 1'b0;

    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    check("stray_ack", {req_ready, resp_valid, mem_req}, 3'b100);

    // Basic refill, write hit, read hit
    clear_log();
    do_req(1'b0, 10'h000, 32'h0);
    check("r0_hit", last_hit, 1'b0);
    check("r0_data", last_rdata, 32'hA000_0000);
    check("r0_nrf", rf_addr_q.size(), 1);
    if (rf_addr_q.size() > 0) check("r0_rfaddr", rf_addr_q[0], 10'h000);
    check("r0_nwb", wb_addr_q.size(), 0);
    check("resp_one_cycle", resp_valid, 1'b0);

    clear_log();
    do_req(1'b1, 10'h000, 32'h0000_00FF);
    check("w0_hit", last_hit, 1'b1);
    check("w0_data", last_rdata, 32'h0000_00FF);
    check("w0_nomem", rf_addr_q.size() + wb_addr_q.size(), 0);

    do_req(1'b0, 10'h000, 32'h0);
    check("r0b_hit", last_hit, 1'b1);
    check("r0b_data", last_rdata, 32'h0000_00FF);

    // Second way of set 0
    clear_log();
    do_req(1'b0, 10'h200, 32'h0);
    check("r200_hit", last_hit, 1'b0);
    check("r200_data", last_rdata, 32'hA000_2000);
    if (rf_addr_q.size() > 0) check("r200_rfaddr", rf_addr_q[0], 10'h200);
    do_req(1'b0, 10'h000, 32'h0);
    check("r0c_hit", last_hit, 1'b1);

    // LRU eviction of clean 0x200, then dirty 0x000
    clear_log();
    do_req(1'b0, 10'h300, 32'h0);
    check("r300_hit", last_hit, 1'b0);
    check("r300_nwb", wb_addr_q.size(), 0);
    if (rf_addr_q.size() > 0) check("r300_rfaddr", rf_addr_q[0], 10'h300);
    check("r300_data", last_rdata, 32'hA000_3000);

    clear_log();
    do_req(1'b0, 10'h200, 32'h0);
    check("r200b_hit", last_hit, 1'b0);
    check("r200b_nwb", wb_addr_q.size(), 1);
    if (wb_addr_q.size() > 0) begin
      check("r200b_wbaddr", wb_addr_q[0], 10'h000);
      check("r200b_wbw0", wb_blk_q[0][31:0], 32'h0000_00FF);
      check("r200b_wbw1", wb_blk_q[0][63:32], 32'hA000_0001);
    end
    check("r200b_nrf", rf_addr_q.size(), 1);
    if (rf_addr_q.size() > 0) check("r200b_rfaddr", rf_addr_q[0], 10'h200);

    do_req(1'b0, 10'h30C, 32'h0);
    check("r30c_hit", last_hit, 1'b1);
    check("r30c_data", last_rdata, 32'hA000_3003);

    // Write miss allocates and merges into the refilled block
    clear_log();
    do_req(1'b1, 10'h024, 32'h0000_1234);
    check("w24_hit", last_hit, 1'b0);
    check("w24_data", last_rdata, 32'h0000_1234);
    check("w24_nwb", wb_addr_q.size(), 0);
    if (rf_addr_q.size() > 0) check("w24_rfaddr", rf_addr_q[0], 10'h020);
    do_req(1'b0, 10'h024, 32'h0);
    check("r24_data", last_rdata, 32'h0000_1234);
    do_req(1'b0, 10'h020, 32'h0);
    check("r20_hit", last_hit, 1'b1);
    check("r20_data", last_rdata, 32'hA000_0200);

    // Flush with dirty lines in both sets and a simultaneous request
    do_reset();
    do_req(1'b1, 10'h000, 32'h0000_0011);
    do_req(1'b1, 10'h014, 32'h0000_0022);
    clear_log();
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h000; flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_busy", {req_ready, resp_valid}, 2'b00);
    wait_evt(1'b1);
    check("fl_nwb", wb_addr_q.size(), 2);
    if (wb_addr_q.size() >= 2) begin
      check("fl_wb0", wb_addr_q[0], 10'h000);
      check("fl_wb0w0", wb_blk_q[0][31:0], 32'h0000_0011);
      check("fl_wb1", wb_addr_q[1], 10'h010);
      check("fl_wb1w1", wb_blk_q[1][63:32], 32'h0000_0022);
    end
    check("fl_nrf", rf_addr_q.size(), 0);
    step();
    check("fl_done_pulse", flush_done, 1'b0);
    clear_log();
    do_req(1'b0, 10'h000, 32'h0);
    check("fl_after_hit", last_hit, 1'b0);
    check("fl_after_data", last_rdata, 32'h0000_0011);
    check("fl_after_nrf", rf_addr_q.size(), 1);

    // Reset in the middle of a refill
    req_valid = 1'b1; req_we = 1'b0; req_addr = 10'h040; req_wdata = '0;
    step();
    req_valid = 1'b0;
    check("mid_req", {mem_req, mem_we}, 2'b10);
    check("mid_addr", mem_addr, 10'h040);
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_outs", {req_ready, resp_valid, mem_req, mem_we, flush_done}, 5'b10000);
    check("mid_rst_addr", mem_addr, 10'h0);
    step();
    reset = 1'b0;
    clear_log();
    do_req(1'b0, 10'h040, 32'h0);
    check("mid_after_hit", last_hit, 1'b0);
    check("mid_after_nrf", rf_addr_q.size(), 1);
    check("mid_after_data", last_rdata, 32'hA000_0400);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
